// File: rtl/oflow_ser_pkg.sv
// Shared definitions for the bounding-box serializer: record/beat geometry,
// field widths and the FSM state encoding.
// Optional feature macro: OFLOW_SER_CHECKSUM_EN adds a trailing XOR checksum beat.
package oflow_ser_pkg;

  localparam int BBOX_W     = 100;
  localparam int BEAT_W     = 32;
  localparam int NUM_BEATS  = 4;
  localparam int BEAT_IDX_W = 2;

  localparam int COORD_W = 11;
  localparam int COLOR_W = 24;
  localparam int HIST_W  = 8;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NUM_BEATS - 1);

  // Field view of the packed record, x in the most significant bits.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COLOR_W-1:0] color1;
    logic [COLOR_W-1:0] color2;
    logic [HIST_W-1:0]  d_history;
  } bbox_t;

`ifdef OFLOW_SER_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CKSUM = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/oflow_ser_beat_mux.sv
// Beat selector: picks one 32-bit word of the latched 100-bit record.
// The last word carries the 4 leftover record bits, left-aligned and zero padded.
module oflow_ser_beat_mux
  import oflow_ser_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic [BBOX_W-1:0]     bbox_i,
  input  logic [BEAT_IDX_W-1:0] beat_idx_i,
  output logic [BEAT_W-1:0]     beat_o
);

  logic [BEAT_IDX_W-1:0] word_idx;

  // LSB-first order walks the words backwards (word3 first).
  assign word_idx = (MSB_FIRST != 0) ? beat_idx_i : (LAST_BEAT - beat_idx_i);

  // Word select from the record.
  always_comb begin
    beat_o = '0;
    case (word_idx)
      2'd0:    beat_o = bbox_i[99:68];
      2'd1:    beat_o = bbox_i[67:36];
      2'd2:    beat_o = bbox_i[35:4];
      2'd3:    beat_o = {bbox_i[3:0], {(BEAT_W-4){1'b0}}};
      default: beat_o = '0;
    endcase
  end

endmodule

// File: rtl/oflow_bbox_serializer.sv
// Bounding-box serializer: accepts one 100-bit record and streams it as four
// 32-bit beats with valid/ready handshaking, counting completed frames.
// Optional feature macro: OFLOW_SER_CHECKSUM_EN appends a fifth beat holding
// the XOR of the four data beats; out_last then marks that beat instead.
module oflow_bbox_serializer
  import oflow_ser_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic [BBOX_W-1:0] bbox,
  input  logic              bbox_valid,
  output logic              bbox_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_t                state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [BBOX_W-1:0]     bbox_q, bbox_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  rdy_q;
  logic [BEAT_W-1:0]     beat_data;
  logic                  accept;
  logic                  out_hs;
`ifdef OFLOW_SER_CHECKSUM_EN
  logic [BEAT_W-1:0]     cksum_q, cksum_d;
`endif

  oflow_ser_beat_mux #(
    .MSB_FIRST (MSB_FIRST)
  ) u_beat_mux (
    .bbox_i     (bbox_q),
    .beat_idx_i (beat_q),
    .beat_o     (beat_data)
  );

  // rdy_q keeps bbox_ready low while reset is held and for the edge that
  // releases it; the record is only accepted from IDLE.
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = busy;
  assign bbox_ready = (state_q == ST_IDLE) && rdy_q;
  assign accept     = bbox_ready && bbox_valid;
  assign out_hs     = out_valid && out_ready;
  assign frame_cnt  = frame_cnt_q;

  // Output beat and end-of-frame marker, decoded from state and beat index so
  // they stay stable for as long as the sink stalls.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      ST_SEND: begin
        out_data = beat_data;
`ifndef OFLOW_SER_CHECKSUM_EN
        out_last = (beat_q == LAST_BEAT);
`endif
      end
`ifdef OFLOW_SER_CHECKSUM_EN
      ST_CKSUM: begin
        out_data = cksum_q;
        out_last = 1'b1;
      end
`endif
      default: begin
        out_data = '0;
        out_last = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept in IDLE, advance beats on handshake, close frame.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    bbox_d      = bbox_q;
    frame_cnt_d = frame_cnt_q;
`ifdef OFLOW_SER_CHECKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bbox_d  = bbox;
          beat_d  = '0;
          state_d = ST_SEND;
`ifdef OFLOW_SER_CHECKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      ST_SEND: begin
        if (out_hs) begin
`ifdef OFLOW_SER_CHECKSUM_EN
          cksum_d = cksum_q ^ beat_data;
`endif
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
`ifdef OFLOW_SER_CHECKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
`endif
          end else begin
            beat_d = beat_q + BEAT_IDX_W'(1);
          end
        end
      end
`ifdef OFLOW_SER_CHECKSUM_EN
      ST_CKSUM: begin
        if (out_hs) begin
          state_d     = ST_IDLE;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Control state, counters and checksum; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      rdy_q       <= 1'b0;
`ifdef OFLOW_SER_CHECKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      rdy_q       <= 1'b1;
`ifdef OFLOW_SER_CHECKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  // Record holding register; only read while a frame is in flight.
  always_ff @(posedge clk) begin
    bbox_q <= bbox_d;
  end

endmodule

// File: tb/tb_oflow_bbox_serializer.sv
// Scoreboard bench for oflow_bbox_serializer. Two instances share stimulus:
// dut0 (MSB_FIRST=1, CNT_W=2) and dut1 (MSB_FIRST=0, CNT_W=16).
// Honours OFLOW_SER_CHECKSUM_EN when the design is built with it.
module tb_oflow_bbox_serializer;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [99:0]      b;
    logic [3:0][31:0] w;
    logic [31:0]      ck;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_N = 1'b0;
  logic [99:0]  bbox = '0;
  logic         bbox_valid = 1'b0;
  logic         out_ready = 1'b1;

  logic         br0, ov0, ol0, bz0, br1, ov1, ol1, bz1;
  logic [31:0]  od0, od1;
  logic [1:0]   fc0;
  logic [15:0]  fc1;

  int tests = 0;
  int fails = 0;

  beat_t exp_q0[$];
  beat_t exp_q1[$];
  int    exp_cnt[2];
  int    cnt_mask[2];
  logic  pend[2];
  logic  stall_v[2];
  logic [31:0] stall_d[2];
  logic  stall_l[2];

  vec_t vecs[4];

  oflow_bbox_serializer #(.MSB_FIRST(1), .CNT_W(2)) dut0 (
    .clk(clk), .reset_N(reset_N), .bbox(bbox), .bbox_valid(bbox_valid),
    .bbox_ready(br0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .out_last(ol0), .busy(bz0), .frame_cnt(fc0)
  );

  oflow_bbox_serializer #(.MSB_FIRST(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset_N(reset_N), .bbox(bbox), .bbox_valid(bbox_valid),
    .bbox_ready(br1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .out_last(ol1), .busy(bz1), .frame_cnt(fc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Per-instance monitor step, run on the falling edge.
  task automatic mon(input int k, input logic [31:0] d, input logic v, input logic l,
                     input logic bz, input logic br, input int fc);
    beat_t e;
    if (pend[k]) begin
      chk("frame_cnt", k, 32'(fc), 32'(exp_cnt[k]));
      chk("ready_after_last", k, 32'(br), 32'd1);
      pend[k] = 1'b0;
    end
    if (stall_v[k]) begin
      chk("hold_valid", k, 32'(v), 32'd1);
      chk("hold_data", k, d, stall_d[k]);
      chk("hold_last", k, 32'(l), 32'(stall_l[k]));
    end
    stall_v[k] = v && !out_ready;
    stall_d[k] = d;
    stall_l[k] = l;
    if (v && out_ready) begin
      tests++;
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        fails++;
        $display("FAIL unexpected_beat dut%0d: got %h expected none", k, d);
      end else begin
        tests--;
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("beat_data", k, d, e.d);
        chk("beat_last", k, 32'(l), 32'(e.l));
        chk("busy", k, 32'(bz), 32'd1);
        if (e.l) begin
          exp_cnt[k] = (exp_cnt[k] + 1) & cnt_mask[k];
          pend[k] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_N) begin
      pend[0] = 1'b0; pend[1] = 1'b0;
      stall_v[0] = 1'b0; stall_v[1] = 1'b0;
    end else begin
      mon(0, od0, ov0, ol0, bz0, br0, int'(fc0));
      mon(1, od1, ov1, ol1, bz1, br1, int'(fc1));
    end
  end

  task automatic push_frame(input vec_t v);
    for (int i = 0; i < 4; i++) begin
`ifdef OFLOW_SER_CHECKSUM_EN
      exp_q0.push_back('{d: v.w[i], l: 1'b0});
      exp_q1.push_back('{d: v.w[3-i], l: 1'b0});
`else
      exp_q0.push_back('{d: v.w[i], l: (i == 3)});
      exp_q1.push_back('{d: v.w[3-i], l: (i == 3)});
`endif
    end
`ifdef OFLOW_SER_CHECKSUM_EN
    exp_q0.push_back('{d: v.ck, l: 1'b1});
    exp_q1.push_back('{d: v.ck, l: 1'b1});
`endif
  endtask

  // Wait for bbox_ready, present the record for one cycle, then scramble bbox.
  task automatic send_frame(input vec_t v);
    int n = 0;
    while (!br0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!br0) begin
      tests++; fails++;
      $display("FAIL ready_timeout dut0: got 0 expected 1");
    end
    push_frame(v);
    bbox = v.b;
    bbox_valid = 1'b1;
    @(posedge clk); #1;
    bbox_valid = 1'b0;
    bbox = ~v.b;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d/%0d beats left expected 0", exp_q0.size(), exp_q1.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input int k, input logic bz, input logic ov, input logic ol,
                              input logic [31:0] od, input logic br, input int fc);
    chk("rst_busy", k, 32'(bz), 32'd0);
    chk("rst_valid", k, 32'(ov), 32'd0);
    chk("rst_last", k, 32'(ol), 32'd0);
    chk("rst_data", k, od, 32'd0);
    chk("rst_ready", k, 32'(br), 32'd0);
    chk("rst_frame_cnt", k, 32'(fc), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    reset_N = 1'b1;
    chk("ready_before_edge", 0, 32'(br0), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_reset", 0, 32'(br0), 32'd1);
    chk("ready_after_reset", 1, 32'(br1), 32'd1);
  endtask

  initial begin
    int n;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    cnt_mask[0] = 3; cnt_mask[1] = 16'hFFFF;
    pend[0] = 1'b0; pend[1] = 1'b0;
    stall_v[0] = 1'b0; stall_v[1] = 1'b0;

    vecs[0] = '{b: {100{1'b1}},
                w: {32'hF0000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, ck: 32'h0FFFFFFF};
    vecs[1] = '{b: 100'h1,
                w: {32'h10000000, 32'h0, 32'h0, 32'h0}, ck: 32'h10000000};
    vecs[2] = '{b: 100'h123456789ABCDEF0123456789,
                w: {32'h90000000, 32'h12345678, 32'h9ABCDEF0, 32'h12345678}, ck: 32'h0ABCDEF0};
    vecs[3] = '{b: 100'h8000000000000000000000000,
                w: {32'h0, 32'h0, 32'h0, 32'h80000000}, ck: 32'h80000000};

    // Power-on reset state.
    #12;
    reset_checks(0, bz0, ov0, ol0, od0, br0, int'(fc0));
    reset_checks(1, bz1, ov1, ol1, od1, br1, int'(fc1));
    release_reset();

    // All-ones record, sink always ready.
    send_frame(vecs[0]);
    drain();
    send_frame(vecs[2]);
    drain();

    // Sink stalls three cycles once the 4th beat of dut0 is presented.
    send_frame(vecs[1]);
    n = 0;
    for (int i = 0; i < 50 && n < 3; i++) begin
      if (ov0 && out_ready) n++;
      if (n < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    send_frame(vecs[3]);
    drain();

    // Reset mid-frame, after the first beat has been accepted.
    send_frame(vecs[2]);
    n = 0;
    while (!(ov0 && out_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    reset_N = 1'b0;
    #1;
    reset_checks(0, bz0, ov0, ol0, od0, br0, int'(fc0));
    reset_checks(1, bz1, ov1, ol1, od1, br1, int'(fc1));
    exp_q0.delete();
    exp_q1.delete();
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    release_reset();

    // Back-to-back frames: dut0 counter wraps 1,2,3,0,1.
    send_frame(vecs[0]);
    send_frame(vecs[1]);
    send_frame(vecs[2]);
    send_frame(vecs[3]);
    send_frame(vecs[0]);
    drain();

    chk("final_frame_cnt", 0, 32'(fc0), 32'd1);
    chk("final_frame_cnt", 1, 32'(fc1), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
